line_fill_responder: RTL and testbench

Memory-side responder for the data cache's line refill and dirty-line writeback requests. Accepts one line-aligned request from the cache miss path, moves a full line as 32-bit beats over a ready-handshaked backing-memory port, streams fill beats back to the cache, and signals completion. Sits between the data cache and the memory arbiter/controller.

---
 rtl/line_fill_responder.sv | 127 ++++++++++++
 tb/tb_line_fill_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - memory-side line fill / dirty-line writeback responder
// Writeback always drains ahead of a simultaneously accepted fill so the fill never overtakes it.
module line_fill_responder #(
    parameter int LineWords = 16
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         FillRequest,
    input  logic [31:0]                  FillAddress,
    input  logic                         WritebackRequest,
    input  logic [31:0]                  WritebackAddress,
    input  logic [31:0]                  WbData,
    output logic                         RequestAccept,
    output logic                         Busy,
    output logic [$clog2(LineWords)-1:0] WbBeat,
    output logic                         WbDone,
    output logic                         FillValid,
    output logic [$clog2(LineWords)-1:0] FillBeat,
    output logic [31:0]                  FillData,
    output logic                         FillDone,
    output logic                         MemRead,
    output logic                         MemWrite,
    output logic [31:0]                  MemAddress,
    output logic [31:0]                  MemWriteData,
    input  logic [31:0]                  MemReadData,
    input  logic                         MemReady
);

    localparam int BeatBits   = $clog2(LineWords);
    localparam int OffsetBits = BeatBits + 2;
    localparam int LineBits   = 32 - OffsetBits;
    localparam logic [BeatBits-1:0] LastBeat = BeatBits'(LineWords - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t                state, state_next;
    logic [BeatBits-1:0]   beat, beat_next;
    logic [LineBits-1:0]   fill_line, wb_line;
    logic                  pending_fill;
    logic                  accept_now;
    logic                  last_beat;
    logic                  unused_offset_bits;

    assign unused_offset_bits = ^{FillAddress[OffsetBits-1:0], WritebackAddress[OffsetBits-1:0]};

    assign accept_now = (state == IDLE) && (FillRequest || WritebackRequest);
    assign last_beat  = MemReady && (beat == LastBeat);

    always_comb begin
        state_next = state;
        beat_next  = beat;
        case (state)
            IDLE: begin
                beat_next = '0;
                if (accept_now)
                    state_next = WritebackRequest ? WB : FILL;
            end
            WB: begin
                if (MemReady) begin
                    beat_next = last_beat ? '0 : beat + BeatBits'(1);
                    if (last_beat)
                        state_next = pending_fill ? FILL : IDLE;
                end
            end
            FILL: begin
                if (MemReady) begin
                    beat_next = last_beat ? '0 : beat + BeatBits'(1);
                    if (last_beat)
                        state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            beat          <= '0;
            fill_line     <= '0;
            wb_line       <= '0;
            pending_fill  <= 1'b0;
            RequestAccept <= 1'b0;
            WbDone        <= 1'b0;
            FillValid     <= 1'b0;
            FillDone      <= 1'b0;
            FillBeat      <= '0;
            FillData      <= '0;
        end else begin
            state         <= state_next;
            beat          <= beat_next;
            RequestAccept <= accept_now;
            WbDone        <= (state == WB) && last_beat;
            FillValid     <= (state == FILL) && MemReady;
            FillDone      <= (state == FILL) && last_beat;
            if (accept_now) begin
                fill_line    <= FillAddress[31:OffsetBits];
                wb_line      <= WritebackAddress[31:OffsetBits];
                pending_fill <= FillRequest;
            end
            if ((state == FILL) && MemReady) begin
                FillData <= MemReadData;
                FillBeat <= beat;
            end
        end
    end

    // Addresses are built from the latched line plus beat, so they can never carry into the next line.
    always_comb begin
        MemAddress = '0;
        case (state)
            WB:      MemAddress = {wb_line, beat, 2'b00};
            FILL:    MemAddress = {fill_line, beat, 2'b00};
            default: MemAddress = '0;
        endcase
    end

    assign Busy         = (state != IDLE);
    assign MemWrite     = (state == WB);
    assign MemRead      = (state == FILL);
    assign WbBeat       = (state == WB) ? beat : '0;
    assign MemWriteData = WbData;

endmodule

// File: tb/tb_line_fill_responder.sv
// tb/tb_line_fill_responder.sv - randomized self-checking bench for line_fill_responder
module tb_line_fill_responder;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        FillRequest;
    logic [31:0] FillAddress;
    logic        WritebackRequest;
    logic [31:0] WritebackAddress;
    logic [31:0] WbData;
    logic        RequestAccept;
    logic        Busy;
    logic [3:0]  WbBeat;
    logic        WbDone;
    logic        FillValid;
    logic [3:0]  FillBeat;
    logic [31:0] FillData;
    logic        FillDone;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;
    logic        MemReady;

    logic [31:0] mem_salt = 32'h0;
    logic [31:0] wb_salt  = 32'hC0DE0000;
    int          errors   = 0;
    int          checks   = 0;

    line_fill_responder #(.LineWords(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .FillRequest(FillRequest), .FillAddress(FillAddress),
        .WritebackRequest(WritebackRequest), .WritebackAddress(WritebackAddress),
        .WbData(WbData), .RequestAccept(RequestAccept), .Busy(Busy),
        .WbBeat(WbBeat), .WbDone(WbDone), .FillValid(FillValid),
        .FillBeat(FillBeat), .FillData(FillData), .FillDone(FillDone),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData), .MemReady(MemReady)
    );

    always #5 Clock = ~Clock;

    // Cache supplies the victim word for the requested beat; memory returns a salted copy of the address.
    assign WbData      = wb_salt ^ ({28'h0, WbBeat} * 32'h00010001);
    assign MemReadData = MemAddress ^ mem_salt;

    function automatic logic [31:0] wb_pattern(input int k);
        return wb_salt ^ (32'(k) * 32'h00010001);
    endfunction

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = three wait cycles before every beat.
    // exp_done: absolute cycle of the final Done pulse, or 0 to take it from the observed last beat.
    task automatic run_txn(input bit do_wb, input bit do_fill, input logic [31:0] wb_addr,
                           input logic [31:0] fill_addr, input int ready_mode, input int exp_done);
        logic [31:0] wb_base, fill_base;
        int wr_k, rd_k, fv_k, accepts, wd_count, fd_count, wc;
        int wb_done_cyc, fill_done_cyc, busy_low_cyc, last_wr_cyc, last_rd_cyc, final_cyc;
        bit done, ready;
        wb_base   = {wb_addr[31:6], 6'b0};
        fill_base = {fill_addr[31:6], 6'b0};
        wr_k = 0; rd_k = 0; fv_k = 0; accepts = 0; wd_count = 0; fd_count = 0; wc = 0;
        wb_done_cyc = -1; fill_done_cyc = -1; busy_low_cyc = -1; last_wr_cyc = -1; last_rd_cyc = -1;
        done = 1'b0;
        @(negedge Clock);
        WritebackRequest = do_wb;
        FillRequest      = do_fill;
        WritebackAddress = wb_addr;
        FillAddress      = fill_addr;
        MemReady         = 1'b1;
        @(posedge Clock);
        for (int c = 1; c <= 400 && !done; c++) begin
            @(negedge Clock);
            if (c == 1) begin
                check("accept_cycle1", 32'(RequestAccept), 1);
                check("busy_cycle1", 32'(Busy), 1);
            end
            if (RequestAccept) begin
                accepts++;
                FillRequest      = 1'b0;
                WritebackRequest = 1'b0;
            end
            check("cmd_exclusive", 32'(MemRead & MemWrite), 0);
            if (MemWrite) begin
                check("wr_addr", MemAddress, wb_base + 32'(4 * wr_k));
                check("wb_beat", 32'(WbBeat), wr_k);
                check("wr_data", MemWriteData, wb_pattern(wr_k));
            end
            if (MemRead) begin
                check("rd_after_wb", wr_k, do_wb ? 16 : 0);
                check("rd_addr", MemAddress, fill_base + 32'(4 * rd_k));
            end
            if (FillValid) begin
                check("fill_beat", 32'(FillBeat), fv_k);
                check("fill_data", FillData, (fill_base + 32'(4 * fv_k)) ^ mem_salt);
                check("fill_done_last", 32'(FillDone), (fv_k == 15) ? 1 : 0);
                fv_k++;
            end
            if (FillDone) begin fd_count++; fill_done_cyc = c; end
            if (WbDone) begin wd_count++; wb_done_cyc = c; end
            if (c > 1 && !Busy) begin busy_low_cyc = c; done = 1'b1; end
            if (ready_mode == 0) ready = 1'b1;
            else if (ready_mode == 1) ready = ($urandom_range(0, 3) != 0);
            else ready = (wc == 3);
            if (MemRead || MemWrite) begin
                if (ready_mode == 2) wc = ready ? 0 : wc + 1;
                if (MemWrite && ready) begin
                    if (wr_k == 15) last_wr_cyc = c;
                    wr_k++;
                end
                if (MemRead && ready) begin
                    if (rd_k == 15) last_rd_cyc = c;
                    rd_k++;
                end
            end
            MemReady = ready;
        end
        check("txn_timeout", 32'(done), 1);
        check("accept_count", accepts, 1);
        check("wr_beats", wr_k, do_wb ? 16 : 0);
        check("rd_beats", rd_k, do_fill ? 16 : 0);
        check("fill_valids", fv_k, do_fill ? 16 : 0);
        check("wb_done_count", wd_count, do_wb ? 1 : 0);
        check("fill_done_count", fd_count, do_fill ? 1 : 0);
        if (do_wb) check("wb_done_cycle", wb_done_cyc, last_wr_cyc + 1);
        if (do_fill) check("fill_done_cycle", fill_done_cyc, last_rd_cyc + 1);
        final_cyc = do_fill ? last_rd_cyc + 1 : last_wr_cyc + 1;
        check("busy_low_cycle", busy_low_cyc, final_cyc);
        if (exp_done != 0) check("done_abs_cycle", do_fill ? fill_done_cyc : wb_done_cyc, exp_done);
        if (do_wb && do_fill && ready_mode == 0) check("wb_done_abs", wb_done_cyc, 17);
    endtask

    initial begin
        int first_acc, second_acc, idle_cyc;
        bit rwb, rfill;
        Reset = 1'b1; FillRequest = 1'b0; WritebackRequest = 1'b0;
        FillAddress = '0; WritebackAddress = '0; MemReady = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_accept", 32'(RequestAccept), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_cmds", {30'h0, MemRead, MemWrite}, 0);
        check("rst_pulses", {29'h0, WbDone, FillValid, FillDone}, 0);
        check("rst_beats", {24'h0, WbBeat, FillBeat}, 0);
        check("rst_fill_data", FillData, 0);
        check("rst_mem_addr", MemAddress, 0);
        Reset = 1'b0;

        run_txn(1'b0, 1'b1, 32'h0, 32'h00001234, 0, 17);
        wb_salt = 32'h5A5A0000; mem_salt = 32'h0F0F0000;
        run_txn(1'b1, 1'b1, 32'h0000A040, 32'h0000B080, 0, 33);
        run_txn(1'b0, 1'b1, 32'h0, 32'h00004400, 2, 65);
        run_txn(1'b0, 1'b1, 32'h0, 32'hFFFFFFC0, 0, 17);

        // Reset in the middle of a fill burst.
        @(negedge Clock);
        FillRequest = 1'b1; FillAddress = 32'h00003000; MemReady = 1'b1;
        @(posedge Clock);
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clock);
            if (RequestAccept) FillRequest = 1'b0;
            if (c == 8) begin
                check("mid_beat7_addr", MemAddress, 32'h0000301C);
                Reset = 1'b1;
            end
        end
        @(negedge Clock);
        check("mid_rst_read", 32'(MemRead), 0);
        check("mid_rst_busy", 32'(Busy), 0);
        check("mid_rst_valid", 32'(FillValid), 0);
        check("mid_rst_done", 32'(FillDone), 0);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            check("post_rst_quiet", {30'h0, FillDone, Busy}, 0);
        end
        run_txn(1'b0, 1'b1, 32'h0, 32'h00003000, 0, 17);

        // A fill request held through a burst is taken only once the responder goes idle.
        first_acc = 0; second_acc = -1; idle_cyc = -1;
        @(negedge Clock);
        FillRequest = 1'b1; FillAddress = 32'h00002000; MemReady = 1'b1;
        @(posedge Clock);
        for (int c = 1; c <= 60 && idle_cyc < 0; c++) begin
            @(negedge Clock);
            if (RequestAccept) begin
                if (c == 1) first_acc++;
                else if (second_acc < 0) second_acc = c;
            end
            if (c == 18) FillRequest = 1'b0;
            if (c > 18 && !Busy) idle_cyc = c;
        end
        check("hold_first_accept", first_acc, 1);
        check("hold_second_accept", second_acc, 18);
        check("hold_second_idle", idle_cyc, 34);

        for (int t = 0; t < 8; t++) begin
            rwb   = 1'($urandom_range(0, 1));
            rfill = rwb ? 1'($urandom_range(0, 1)) : 1'b1;
            wb_salt  = $urandom;
            mem_salt = $urandom;
            run_txn(rwb, rfill, $urandom, $urandom, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
